mem_port_arbiter: RTL and testbench

Shares the single byte-wide, 512-location program/data memory between the pipeline's IF stage (instruction fetch) and MEM stage (LBU/SB-class loads and stores). Each granted access is sequenced as 1, 2 or 4 byte beats, assembled or split big-endian, with zero or sign extension applied on loads. One completion pulse is returned per request. The pipeline uses the pending-request / done handshake to drive its PC and stage load enables (stall until done).

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_byte_packer.sv | 36 +++
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared states, size/owner codes and beat-count helper for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_BEAT = 2'd1,
    WR_BEAT = 2'd2
  } arb_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  // Size code 2'b11 is treated as a word.
  function automatic logic [2:0] beats(input logic [1:0] size);
    case (size)
      SIZE_BYTE: beats = 3'd1;
      SIZE_HALF: beats = 3'd2;
      default:   beats = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_packer.sv
// rtl/mem_byte_packer.sv - load extension and big-endian store byte selection
module mem_byte_packer
  import mem_arb_pkg::*;
(
  input  logic [31:0] acc_i,
  input  logic [1:0]  size_i,
  input  logic        se_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  beat_i,
  output logic [31:0] rdata_o,
  output logic [7:0]  wbyte_o
);

  logic [2:0] byte_idx;

  always_comb begin
    case (size_i)
      SIZE_BYTE: rdata_o = {{24{se_i & acc_i[7]}}, acc_i[7:0]};
      SIZE_HALF: rdata_o = {{16{se_i & acc_i[15]}}, acc_i[15:0]};
      default:   rdata_o = acc_i;
    endcase
  end

  // First beat carries the most significant byte in use.
  assign byte_idx = beats(size_i) - 3'd1 - {1'b0, beat_i};

  always_comb begin
    case (byte_idx)
      3'd0:    wbyte_o = wdata_i[7:0];
      3'd1:    wbyte_o = wdata_i[15:8];
      3'd2:    wbyte_o = wdata_i[23:16];
      default: wbyte_o = wdata_i[31:24];
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one byte-wide memory between fetch and data ports with byte beats
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 9,
  parameter int MEM_BYTES = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [1:0]        d_size,
  input  logic              d_se,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEM_BYTES - 1);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              rr_last_q, rr_last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              se_q, se_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        beat_q, beat_d;
  logic [31:0]       acc_q, acc_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;

  logic              if_pend, d_pend, grant_d, grant_if;
  logic              last_beat;
  logic [ADDR_W-1:0] addr_next;
  logic [31:0]       acc_shift;
  logic [31:0]       load_ext;
  logic [7:0]        wr_byte;

  // A requester in its own done cycle still holds req; mask it to avoid a double grant.
  assign if_pend  = if_req & ~if_done_q;
  assign d_pend   = d_req & ~d_done_q;
  assign grant_d  = d_pend & (~if_pend | (rr_last_q == OWN_IF));
  assign grant_if = if_pend & ~grant_d;

  assign last_beat = (({1'b0, beat_q} + 3'd1) == beats(size_q));
  assign addr_next = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);
  assign acc_shift = {acc_q[23:0], mem_rdata};

  mem_byte_packer u_packer (
    .acc_i   (acc_shift),
    .size_i  (size_q),
    .se_i    (se_q),
    .wdata_i (wdata_q),
    .beat_i  (beat_q),
    .rdata_o (load_ext),
    .wbyte_o (wr_byte)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_last_d  = rr_last_q;
    addr_d     = addr_q;
    size_d     = size_q;
    se_d       = se_q;
    wdata_d    = wdata_q;
    beat_d     = beat_q;
    acc_d      = acc_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_done_d  = 1'b0;
    d_done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_d || grant_if) begin
          owner_d   = grant_d ? OWN_D : OWN_IF;
          rr_last_d = grant_d ? OWN_D : OWN_IF;
          addr_d    = grant_d ? d_addr : if_addr;
          size_d    = grant_d ? d_size : SIZE_WORD;
          se_d      = grant_d & d_se;
          wdata_d   = d_wdata;
          beat_d    = 2'd0;
          state_d   = (grant_d && d_rw) ? WR_BEAT : RD_BEAT;
        end
      end
      RD_BEAT, WR_BEAT: begin
        if (state_q == RD_BEAT) acc_d = acc_shift;
        beat_d = beat_q + 2'd1;
        addr_d = addr_next;
        if (last_beat) begin
          state_d = IDLE;
          if (owner_q == OWN_IF) begin
            if_done_d  = 1'b1;
            if_rdata_d = load_ext;
          end else begin
            d_done_d = 1'b1;
            if (state_q == RD_BEAT) d_rdata_d = load_ext;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      rr_last_q  <= OWN_IF;
      addr_q     <= '0;
      size_q     <= SIZE_BYTE;
      se_q       <= 1'b0;
      wdata_q    <= '0;
      beat_q     <= '0;
      acc_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_last_q  <= rr_last_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      se_q       <= se_d;
      wdata_q    <= wdata_d;
      beat_q     <= beat_d;
      acc_q      <= acc_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_done_q  <= if_done_d;
      d_done_q   <= d_done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign mem_we    = (state_q == WR_BEAT);
  assign mem_addr  = busy ? addr_q : '0;
  assign mem_wdata = mem_we ? wr_byte : 8'h00;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter against a byte-array reference model
module tb_mem_port_arbiter;

  localparam int AW = 9;
  localparam int MB = 512;

  logic          clk;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          if_done;
  logic          d_req;
  logic          d_rw;
  logic [1:0]    d_size;
  logic          d_se;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic [31:0]   d_rdata;
  logic          d_done;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic          busy;

  mem_port_arbiter #(.ADDR_W(AW), .MEM_BYTES(MB)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_rw(d_rw), .d_size(d_size), .d_se(d_se), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memory and its independent reference copy.
  logic [7:0]    mem [0:MB-1];
  logic [7:0]    ref_mem [0:MB-1];
  logic          poke_en;
  logic [AW-1:0] poke_addr;
  logic [7:0]    poke_data;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (poke_en) mem[poke_addr] <= poke_data;
  end

  typedef struct { logic [AW-1:0] addr; logic we; logic [7:0] wdata; } beat_t;
  typedef struct { bit own_d; logic [31:0] exp_if; logic [31:0] exp_d; } done_t;

  beat_t       beat_q[$];
  done_t       done_q[$];
  bit          m_prefer_d;
  logic [31:0] m_if, m_d;
  int          n_checks, n_pass;
  bit          mon_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic poke(input int a, input logic [7:0] v);
    ref_mem[a] = v;
    poke_en = 1'b1;
    poke_addr = a[AW-1:0];
    poke_data = v;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  function automatic int nbeats(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  // Reference: walk bytes big-endian over the array, then extend the assembled value.
  task automatic predict(input bit own_d, input bit rw, input logic [1:0] size, input bit se,
                         input int addr, input logic [31:0] wd);
    int n;
    logic [31:0] v;
    beat_t b;
    done_t e;
    n = own_d ? nbeats(size) : 4;
    v = 32'd0;
    for (int i = 0; i < n; i++) begin
      int a;
      a = (addr + i) % MB;
      b.addr = a[AW-1:0];
      b.we = rw;
      if (rw) begin
        b.wdata = 8'((wd >> (8 * (n - 1 - i))) & 32'hFF);
        ref_mem[a] = b.wdata;
      end else begin
        b.wdata = 8'h00;
        v = (v << 8) | {24'd0, ref_mem[a]};
      end
      beat_q.push_back(b);
    end
    if (!rw) begin
      if (n == 1) v = (se && v[7]) ? (v | 32'hFFFFFF00) : (v & 32'h000000FF);
      if (n == 2) v = (se && v[15]) ? (v | 32'hFFFF0000) : (v & 32'h0000FFFF);
      if (own_d) m_d = v;
      else m_if = v;
    end
    m_prefer_d = !own_d;
    e.own_d = own_d;
    e.exp_if = m_if;
    e.exp_d = m_d;
    done_q.push_back(e);
  endtask

  task automatic run_req(input bit own_d, input bit rw, input logic [1:0] size, input bit se,
                         input int addr, input logic [31:0] wd);
    int lat;
    int n;
    n = own_d ? nbeats(size) : 4;
    predict(own_d, rw, size, se, addr, wd);
    @(posedge clk);
    #1;
    if (own_d) begin
      d_req = 1'b1; d_rw = rw; d_size = size; d_se = se;
      d_addr = addr[AW-1:0]; d_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr[AW-1:0];
    end
    lat = 0;
    forever begin
      @(negedge clk);
      if (own_d ? d_done : if_done) break;
      lat++;
      if (lat > 12) break;
      // Fields are latched at grant; disturb them afterwards.
      if (lat >= 2) begin
        if (own_d) begin
          d_rw = 1'($urandom); d_size = 2'($urandom); d_se = 1'($urandom);
          d_addr = AW'($urandom); d_wdata = $urandom;
        end else begin
          if_addr = AW'($urandom);
        end
      end
    end
    if (own_d) d_req = 1'b0;
    else if_req = 1'b0;
    chk(own_d ? "d_latency" : "if_latency", 32'(lat), 32'(n + 1));
  endtask

  task automatic model_reset();
    m_prefer_d = 1'b1;
    m_if = 32'd0;
    m_d = 32'd0;
  endtask

  always @(negedge clk) begin : monitor
    beat_t b;
    done_t e;
    if (mon_en && reset) begin
      if (busy) begin
        if (beat_q.size() == 0) begin
          chk("beat_unexpected", 32'(busy), 32'd0);
        end else begin
          b = beat_q.pop_front();
          chk("beat_addr", 32'(mem_addr), 32'(b.addr));
          chk("beat_we", 32'(mem_we), 32'(b.we));
          if (b.we) chk("beat_wdata", 32'(mem_wdata), 32'(b.wdata));
        end
      end else begin
        chk("idle_bus", {mem_addr, mem_we, mem_wdata}, 32'd0);
      end
      if (if_done || d_done) begin
        chk("single_done", 32'(if_done & d_done), 32'd0);
        if (done_q.size() == 0) begin
          chk("done_unexpected", 32'(if_done | d_done), 32'd0);
        end else begin
          e = done_q.pop_front();
          chk("done_owner", 32'(d_done), 32'(e.own_d));
          chk("if_rdata", if_rdata, e.exp_if);
          chk("d_rdata", d_rdata, e.exp_d);
        end
      end
    end
  end

  initial begin
    int cyc, ndone, first_d, first_if;
    n_checks = 0; n_pass = 0; mon_en = 1'b0;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    reset = 1'b0;
    if_req = 0; if_addr = '0; d_req = 0; d_rw = 0; d_size = 0; d_se = 0; d_addr = '0; d_wdata = 0;
    model_reset();

    // Reset with random inputs: all outputs stay zero.
    for (int i = 0; i < 6; i++) begin
      if_req = 1'($urandom); if_addr = AW'($urandom);
      d_req = 1'($urandom); d_rw = 1'($urandom); d_size = 2'($urandom); d_se = 1'($urandom);
      d_addr = AW'($urandom); d_wdata = $urandom;
      @(negedge clk);
      chk("rst_done", {30'd0, if_done, d_done}, 32'd0);
      chk("rst_bus", {mem_addr, mem_we, mem_wdata, busy}, 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
    end
    if_req = 0; d_req = 0;
    for (int i = 0; i < MB; i++) poke(i, 8'($urandom));
    @(posedge clk); #1 reset = 1'b1;
    mon_en = 1'b1;

    // IF word read
    poke('h10, 8'hDE); poke('h11, 8'hAD); poke('h12, 8'hBE); poke('h13, 8'hEF);
    run_req(1'b0, 1'b0, 2'b10, 1'b0, 'h10, 32'd0);
    chk("if_word", if_rdata, 32'hDEADBEEF);

    // Byte loads zero/sign extended; halfword sign extended
    poke('h20, 8'h9C);
    run_req(1'b1, 1'b0, 2'b00, 1'b0, 'h20, 32'd0);
    chk("lbu_zext", d_rdata, 32'h0000009C);
    run_req(1'b1, 1'b0, 2'b00, 1'b1, 'h20, 32'd0);
    chk("lb_sext", d_rdata, 32'hFFFFFF9C);
    poke('h30, 8'h80); poke('h31, 8'h01);
    run_req(1'b1, 1'b0, 2'b01, 1'b1, 'h30, 32'd0);
    chk("lh_sext", d_rdata, 32'hFFFF8001);

    // Stores at the top of memory, including wrap
    run_req(1'b1, 1'b1, 2'b00, 1'b0, 'h1FF, 32'h12345678);
    chk("sb_keeps_rdata", d_rdata, 32'hFFFF8001);
    run_req(1'b1, 1'b1, 2'b10, 1'b0, 'h1FE, 32'h12345678);
    run_req(1'b1, 1'b0, 2'b11, 1'b0, 'h1FE, 32'd0);
    chk("wrap_word_load", d_rdata, 32'h12345678);

    // Random single-requester traffic
    for (int k = 0; k < 150; k++) begin
      bit own, rw;
      own = 1'($urandom);
      rw = own ? 1'($urandom) : 1'b0;
      run_req(own, rw, 2'($urandom), 1'($urandom), int'($urandom_range(MB - 1, 0)), $urandom);
      repeat ($urandom_range(2, 0)) @(posedge clk);
    end

    // Both requesters from reset: D first, then strict alternation
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      if (m_prefer_d) predict(1'b1, 1'b0, 2'b00, 1'b1, 'h180, 32'd0);
      else predict(1'b0, 1'b0, 2'b10, 1'b0, 'h100, 32'd0);
    end
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 'h100;
    d_req = 1'b1; d_rw = 1'b0; d_size = 2'b00; d_se = 1'b1; d_addr = 'h180;
    cyc = 0; ndone = 0; first_d = -1; first_if = -1;
    while (ndone < 4 && cyc < 60) begin
      @(negedge clk);
      if (d_done) begin if (first_d < 0) first_d = cyc; ndone++; end
      if (if_done) begin if (first_if < 0) first_if = cyc; ndone++; end
      if (ndone >= 4) break;
      cyc++;
    end
    if_req = 1'b0; d_req = 1'b0;
    chk("arb_dones", 32'(ndone), 32'd4);
    chk("arb_first_d_cycle", 32'(first_d), 32'd2);
    chk("arb_first_if_cycle", 32'(first_if), 32'd7);
    repeat (3) @(negedge clk);
    chk("arb_idle", 32'(busy), 32'd0);

    // Reset during beat 2 of a word store: first two bytes stay written
    poke('h0F0, 8'h11); poke('h0F1, 8'h22); poke('h0F2, 8'h33); poke('h0F3, 8'h44);
    beat_q.push_back('{addr: AW'('h0F0), we: 1'b1, wdata: 8'hA1});
    beat_q.push_back('{addr: AW'('h0F1), we: 1'b1, wdata: 8'hB2});
    ref_mem['h0F0] = 8'hA1;
    ref_mem['h0F1] = 8'hB2;
    @(posedge clk); #1;
    d_req = 1'b1; d_rw = 1'b1; d_size = 2'b10; d_se = 1'b0; d_addr = 'h0F0; d_wdata = 32'hA1B2C3D4;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; d_req = 1'b0;
    #1;
    chk("abort_we", 32'(mem_we), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", {30'd0, if_done, d_done}, 32'd0);
    end
    run_req(1'b1, 1'b0, 2'b10, 1'b0, 'h0F0, 32'd0);
    chk("abort_partial", d_rdata, 32'hA1B23344);

    repeat (3) @(negedge clk);
    chk("beat_q_empty", 32'(beat_q.size()), 32'd0);
    chk("done_q_empty", 32'(done_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
